// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1-style UART receive deserializer.
//
// The serial line is oversampled with the system clock. A falling edge on
// the synchronized line starts a frame; the start bit is re-checked at its
// midpoint, and then every data bit and the stop bit is sampled one full bit
// period after the previous sample, which lands near the middle of each bit.
//
// Ports:
//   clk          system clock, all logic on posedge
//   arstn        asynchronous active-low reset
//   rx_i         asynchronous serial line, idles high
//   valid_o      one-cycle pulse: data_o holds a newly received word
//   data_o       last good word, held until the next valid_o
//   frame_err_o  one-cycle pulse: stop bit was sampled low
//   busy_o       high whenever the receiver is not idle
//
// Output handshake: valid_o is a push-only strobe with no ready/backpressure.
// The downstream FIFO must take data_o in the cycle valid_o is high; a word
// is never repeated or held for acceptance.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             rx_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Fewer than 4 clocks per bit leaves no room to find a bit midpoint.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx: CLKS_PER_BIT=%0d is below the minimum of 4", CLKS_PER_BIT);
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Both flops reset high (the idle level) so leaving
  // reset can never look like a start edge.
  // -------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM
  // -------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic               valid_q, valid_d;
  logic               ferr_q,  ferr_d;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      // Re-check the start bit half a bit in; a line that is already high
      // again was a glitch and is dropped silently.
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Sampling is now phase-locked to the start-bit midpoint, so one full
      // bit period later is the middle of the next bit. LSB arrives first.
      S_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaving at mid-stop-bit gives half a bit of slack to catch the next
      // start edge, which is what allows gapless back-to-back frames.
      S_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A line stuck low (break condition) must return high before another
      // start bit is accepted, otherwise it would decode as endless 0x00.
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at CLKS_PER_BIT = 10.
//
// Frames are driven on rx_i with real-time bit periods (1 ns = 0.1 clock),
// so baud error is modelled directly. A monitor captures every output pulse
// as {busy_o, frame_err_o, data_o} with its cycle number; each frame sent
// pushes the event it should produce into exp_q, and expect_event matches
// them in order, also checking latency and back-to-back spacing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;                 // 10
  localparam int HALF_B   = CPB / 2;                         // 5
  localparam int LAT      = 2 + HALF_B + 9 * CPB + 1;        // 98
  localparam int N_RAND   = 40;

  logic       clk;
  logic       arstn;
  logic       rx_i;
  logic       valid_o;
  logic [7:0] data_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WIDTH(8)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .rx_i        (rx_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and checks ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- monitor ----------------
  logic [9:0] obs_q[$];      // {busy, frame_err, data}
  int         obs_cyc_q[$];
  bit         prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (valid_o || frame_err_o) begin
      obs_q.push_back({busy_o, frame_err_o, data_o});
      obs_cyc_q.push_back(cyc);
      check("pulse_exclusive", int'(valid_o & frame_err_o), 0);
      check("pulse_one_cycle", int'(prev_pulse), 0);
    end
    prev_pulse = valid_o | frame_err_o;
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];      // {frame_err, expected data_o}
  int         per_q[$];
  int         gap_q[$];
  int         start_q[$];
  logic [7:0] last_good = 8'h00;
  int         prev_c    = 0;
  bit         prev_ok   = 1'b0;

  // Queue the expected outcome of one frame using the protocol rules:
  // good stop bit -> valid with the byte; bad stop bit -> error, data held.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input int per, input int gap);
    if (stop_ok) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    per_q.push_back(per);
    gap_q.push_back(gap);
  endtask

  // ---------------- driver ----------------
  // per: bit period in ns (tenths of a clock). gap > 0 idles high for gap
  // clocks and realigns to 1 ns after a rising edge; gap == 0 continues
  // straight out of the previous stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int per,
                            input int gap, input int extra_low);
    if (gap > 0) begin
      rx_i = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
    end
    start_q.push_back(cyc + 1);
    rx_i = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      #(per);
    end
    rx_i = stop_ok;
    #(per);
    if (!stop_ok) #(extra_low * 10);
    rx_i = 1'b1;
  endtask

  task automatic expect_event(input string name);
    int         waited;
    int         c, st, per, gap;
    logic [9:0] ev;
    logic [8:0] exp_ev;
    waited = 0;
    while (obs_q.size() == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    exp_ev = exp_q.pop_front();
    per    = per_q.pop_front();
    gap    = gap_q.pop_front();
    if (obs_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no output pulse within %0d clocks, expected err=%0d data=0x%02h",
               name, waited, exp_ev[8], exp_ev[7:0]);
      if (start_q.size() > 0) void'(start_q.pop_front());
      prev_ok = 1'b0;
      return;
    end
    ev = obs_q.pop_front();
    c  = obs_cyc_q.pop_front();
    st = start_q.pop_front();
    check({name, "_kind"}, int'(ev[8]), int'(exp_ev[8]));
    check({name, "_data"}, int'(ev[7:0]), int'(exp_ev[7:0]));
    check({name, "_busy"}, int'(ev[9]), int'(exp_ev[8]));
    if (per == 100) check_range({name, "_latency"}, c - st, LAT - 1, LAT + 1);
    if (gap == 0 && per == 100 && prev_ok) check({name, "_spacing"}, c - prev_c, 10 * CPB);
    prev_c  = c;
    prev_ok = (per == 100);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         per;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int busy_cnt;
    logic [7:0] b;
    bit ok;
    int per, gap, prev_per;
    bit prv_ok;
    logic [7:0] abort_b;

    vecs[0] = '{8'hA5, 1'b1, 100, 4, 1'b1, 8'hA5};
    vecs[1] = '{8'h01, 1'b1, 100, 4, 1'b1, 8'h01};
    vecs[2] = '{8'h02, 1'b1, 100, 0, 1'b1, 8'h02};
    vecs[3] = '{8'h03, 1'b1, 100, 0, 1'b1, 8'h03};
    vecs[4] = '{8'h04, 1'b1, 100, 0, 1'b1, 8'h04};
    vecs[5] = '{8'h05, 1'b1, 100, 0, 1'b1, 8'h05};
    vecs[6] = '{8'hC3, 1'b1, 102, 4, 1'b1, 8'hC3};
    vecs[7] = '{8'hC3, 1'b1,  98, 4, 1'b1, 8'hC3};

    // ---- reset state ----
    arstn = 1'b0;
    rx_i  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", int'(valid_o), 0);
    check("reset_data", int'(data_o), 0);
    check("reset_ferr", int'(frame_err_o), 0);
    check("reset_busy", int'(busy_o), 0);
    arstn = 1'b1;
    repeat (5) @(posedge clk);

    // ---- table: single frame, back-to-back burst, +/-2% baud ----
    fork
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back({~vecs[i].exp_valid, vecs[i].exp_data});
        per_q.push_back(vecs[i].per);
        gap_q.push_back(vecs[i].gap);
        if (vecs[i].exp_valid) last_good = vecs[i].exp_data;
        send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].per, vecs[i].gap, 0);
      end
      for (int i = 0; i < 8; i++) begin
        expect_event($sformatf("vec%0d", i));
      end
    join

    // ---- short glitch: 3 clocks low ----
    repeat (20) @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i = 1'b1;
    busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
    end
    check_range("glitch_busy_clks", busy_cnt, 1, CPB - 1);
    check("glitch_no_pulse", obs_q.size(), 0);
    check("glitch_idle", int'(busy_o), 0);

    // ---- bad stop bit, line held low, then a good frame ----
    prev_ok = 1'b0;
    fork
      begin
        model_frame(8'h3C, 1'b0, 100, 4);
        send_frame(8'h3C, 1'b0, 100, 4, 30);
        model_frame(8'h7E, 1'b1, 100, 4);
        send_frame(8'h7E, 1'b1, 100, 4, 0);
      end
      begin
        expect_event("stop_low_err");
        expect_event("after_break");
      end
    join

    // ---- reset during data bit 4, then 0x55 ----
    abort_b = 8'hA6;
    repeat (10) @(posedge clk);
    #1;
    rx_i = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      rx_i = abort_b[i];
      #100;
    end
    rx_i = abort_b[4];
    #50;
    arstn = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_data", int'(data_o), 0);
    check("midrst_ferr", int'(frame_err_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    repeat (3) @(negedge clk);
    rx_i  = 1'b1;
    arstn = 1'b1;
    last_good = 8'h00;
    repeat (20) @(posedge clk);
    check("midrst_no_pulse", obs_q.size(), 0);
    prev_ok = 1'b0;
    fork
      begin
        model_frame(8'h55, 1'b1, 100, 2);
        send_frame(8'h55, 1'b1, 100, 2, 0);
      end
      expect_event("after_reset");
    join

    // ---- randomized frames vs. protocol model ----
    prev_per = 100;
    prv_ok   = 1'b1;
    fork
      for (int i = 0; i < N_RAND; i++) begin
        b   = 8'($urandom_range(0, 255));
        ok  = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 2))
          0:       per = 98;
          1:       per = 102;
          default: per = 100;
        endcase
        gap = $urandom_range(0, 12);
        if (gap == 0 && (per != 100 || prev_per != 100)) gap = 1;
        if (!prv_ok && gap < 4) gap = 4;
        model_frame(b, ok, per, gap);
        send_frame(b, ok, per, gap, 0);
        prev_per = per;
        prv_ok   = ok;
      end
      for (int i = 0; i < N_RAND; i++) begin
        expect_event($sformatf("rand%0d", i));
      end
    join

    // ---- drain ----
    repeat (200) @(negedge clk);
    check("no_extra_pulses", obs_q.size(), 0);
    check("final_idle", int'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive deserializer: 8N1-style async serial line in, one parallel word out per frame.
- Sits directly upstream of the UART RX frame-collecting FIFO.
- valid_o / data_o connect straight to that FIFO's push / write_data.
- Oversamples the line with the system clock and samples each bit at its midpoint.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line baud rate in bit/s.
- WIDTH, 8, data bits per frame, sent LSB first.
- Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD, integer division, 434 at defaults.
- Derived localparam HALF = CLKS_PER_BIT / 2.
- Elaboration must fail if CLKS_PER_BIT < 4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- arstn  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- rx_i  in  1  asynchronous serial line; idles high.
- valid_o  out  1  one-cycle pulse when data_o holds a newly received word.
- data_o  out  WIDTH  last received word; held stable until the next valid_o.
- frame_err_o  out  1  one-cycle pulse when the stop bit is sampled low.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- **Synchronizer**
  - rx_i passes through a 2-flop synchronizer; the output is rx_s.
  - Both flops reset to 1, so a release from reset never produces a false start.
- **Reset (arstn=0, any time, including mid-frame)**
  - state=IDLE, cnt=0, shift register=0.
  - valid_o=0, data_o=0, frame_err_o=0, busy_o=0.
  - No partial word is ever emitted after reset.
- **Counter**
  - cnt is wide enough for CLKS_PER_BIT-1.
  - Zeroed on every state change and after every bit sample.
- **IDLE**
  - If rx_s==0 at a clock edge, go to START with cnt=0; otherwise stay.
- **START**
  - cnt increments each clock.
  - When cnt==HALF-1, sample rx_s:
    - 0: go to DATA, cnt=0, bit index=0.
    - 1: glitch or false start; go to IDLE with no output pulse.
- **DATA**
  - When cnt==CLKS_PER_BIT-1, sample rx_s into shift-register bit [index]; LSB is received first.
  - After WIDTH samples, go to STOP.
- **STOP**
  - When cnt==CLKS_PER_BIT-1, sample rx_s:
    - 1: on the next edge valid_o=1 and data_o=shift register; go to IDLE.
    - 0: on the next edge frame_err_o=1 and data_o is unchanged; go to BREAK.
- **BREAK**
  - Wait until rx_s==1, then go to IDLE.
  - Prevents a held-low line from being decoded as repeated 0x00 frames.
- **Pulse widths**
  - valid_o and frame_err_o are exactly one clock wide.
  - They are never high together.
- **Back-to-back frames**
  - Returning to IDLE at mid-stop-bit allows the next start edge to be caught with no gap.
  - Must sustain continuous frames at BAUD.
- **Latency**
  - Counted from the first clock edge at which rx_i is sampled low to the valid_o rising edge.
  - Equal to 2 + HALF + (WIDTH+1)*CLKS_PER_BIT + 1 clocks (synchronizer + half bit + data + stop + register).
  - Bench tolerance is ±1 clock.
- **Baud tolerance**
  - Must receive correctly with a transmitter baud error of ±2%.

Test Plan:
- Parameters for the directed tests: CLK_FREQ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10, HALF=5).
- Send 0xA5 as a single 8N1 frame → exactly one valid_o pulse, data_o=0xA5, frame_err_o never high, busy_o returns to 0 after the pulse.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no idle bits → five valid_o pulses in order with data_o=0x01…0x05, each one frame (100 clocks) apart.
- Pull rx_i low for 3 clocks, then high → no valid_o, no frame_err_o, busy_o high for fewer than 10 clocks, then IDLE.
- Send 0x3C with the stop bit forced low, hold the line low 30 more clocks, then send 0x7E normally:
  - one frame_err_o pulse with data_o still at its prior value;
  - no output while the line is held low;
  - then valid_o with data_o=0x7E.
- Assert arstn low during data bit 4 of a frame, release it, then send 0x55 → all outputs 0 during reset, no pulse for the aborted frame, then valid_o with data_o=0x55.
- Send 0xC3 with the bit period stretched to 10.2 clocks (+2%), then 0xC3 at 9.8 clocks (−2%) → data_o=0xC3 both times, no frame_err_o.
